dtpu_batch_ctrl: RTL and testbench

//  Batch sequencer for the MXU datapath. One cs_start runs cfg_batch_len input words end to end:

---
 rtl/dtpu_batch_ctrl_pkg.sv | 32 +++
 rtl/dtpu_valid_pipe.sv | 40 ++++
 rtl/dtpu_batch_ctrl.sv | 141 ++++++++++++++
 tb/tb_dtpu_batch_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtpu_batch_ctrl_pkg.sv
// Shared definitions for the MXU batch sequencer: state encodings, precision codes
// and the skewed-pipeline depth formula.
package dtpu_batch_ctrl_pkg;

  localparam int unsigned ROWS_DEF               = 3;
  localparam int unsigned COLUMNS_DEF            = 3;
  localparam int unsigned MXU_LATENCY_DEF        = 2;
  localparam int unsigned MAX_BATCH_DEF          = 4096;
  localparam int unsigned LOG_ALLOWED_PRECISIONS = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [LOG_ALLOWED_PRECISIONS-1:0] {
    PREC_INT8 = 2'd0,
    PREC_INT4 = 2'd1,
    PREC_INT2 = 2'd2,
    PREC_BIN  = 2'd3
  } prec_e;

  // A word needs the MAC stages plus the row/column skew before it leaves the array.
  function automatic int unsigned pipe_depth(input int unsigned lat,
                                             input int unsigned rows,
                                             input int unsigned cols);
    return lat + rows + cols - 1;
  endfunction

endpackage

// File: rtl/dtpu_valid_pipe.sv
// Freezable valid-bit shift register mirroring words in flight through the skewed MXU pipe.
// Reports the bit at the head and how many valid words are currently inside.
module dtpu_valid_pipe #(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv_i,
  input  logic             valid_i,
  output logic             head_valid_o,
  output logic [OCC_W-1:0] occupancy_o
);

  logic [DEPTH-1:0] pipe_q, pipe_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    pipe_d = pipe_q;
    occ_d  = occ_q;
    if (adv_i) begin
      pipe_d = {pipe_q[DEPTH-2:0], valid_i};
      occ_d  = occ_q + OCC_W'(valid_i) - OCC_W'(pipe_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
      occ_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      occ_q  <= occ_d;
    end
  end

  assign head_valid_o = pipe_q[DEPTH-1];
  assign occupancy_o  = occ_q;

endmodule

// File: rtl/dtpu_batch_ctrl.sv
// Batch sequencer for the MXU datapath: input FIFO -> MXU -> output FIFO with
// back-pressure freeze and ap_ctrl_chain handshake.
//
// state | meaning
// IDLE  | waiting for cs_start; cs_idle high
// RUN   | issuing words from the input FIFO until len words are read
// DRAIN | all words issued; waiting for the pipe to deliver the rest
// DONE  | batch complete; cs_done held until cs_continue
module dtpu_batch_ctrl
  import dtpu_batch_ctrl_pkg::*;
#(
  parameter int unsigned ROWS        = ROWS_DEF,
  parameter int unsigned COLUMNS     = COLUMNS_DEF,
  parameter int unsigned MXU_LATENCY = MXU_LATENCY_DEF,
  parameter int unsigned MAX_BATCH   = MAX_BATCH_DEF,
  parameter int unsigned CNT_W       = $clog2(MAX_BATCH + 1),
  parameter int unsigned PREC_W      = LOG_ALLOWED_PRECISIONS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              glb_enable,
  input  logic              cs_start,
  input  logic              cs_continue,
  output logic              cs_ready,
  output logic              cs_done,
  output logic              cs_idle,
  input  logic [CNT_W-1:0]  cfg_batch_len,
  input  logic [PREC_W-1:0] cfg_precision,
  output logic [PREC_W-1:0] data_precision,
  input  logic              infifo_is_empty,
  output logic              infifo_read,
  input  logic              outfifo_is_full,
  output logic              outfifo_write,
  output logic              enable_mxu,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [3:0]        state_out
);

  localparam int unsigned      PIPE_DEPTH = pipe_depth(MXU_LATENCY, ROWS, COLUMNS);
  localparam int unsigned      OCC_W      = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_LEN    = CNT_W'(MAX_BATCH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  written_q, written_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [PREC_W-1:0] prec_q, prec_d;

  logic             active, head_valid, stall_evt, adv, rd, wr, accept;
  logic [CNT_W-1:0] clamped_len;
  logic [OCC_W-1:0] occupancy;

  always_comb begin
    active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    stall_evt   = glb_enable & active & head_valid & outfifo_is_full;
    adv         = glb_enable & active & ~(head_valid & outfifo_is_full);
    rd          = adv & (state_q == ST_RUN) & (issued_q < len_q) & ~infifo_is_empty;
    wr          = adv & head_valid;
    accept      = glb_enable & cs_start & (state_q == ST_IDLE);
    clamped_len = (cfg_batch_len > MAX_LEN) ? MAX_LEN : cfg_batch_len;
  end

  dtpu_valid_pipe #(
    .DEPTH(PIPE_DEPTH),
    .OCC_W(OCC_W)
  ) u_valid_pipe (
    .clk         (clk),
    .reset       (reset),
    .adv_i       (adv),
    .valid_i     (rd),
    .head_valid_o(head_valid),
    .occupancy_o (occupancy)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    prec_d    = prec_q;
    issued_d  = issued_q + CNT_W'(rd);
    written_d = written_q + CNT_W'(wr);
    stall_d   = (stall_evt && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d     = clamped_len;
          prec_d    = cfg_precision;
          issued_d  = '0;
          written_d = '0;
          stall_d   = '0;
          state_d   = (clamped_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      // issued_d already includes this cycle's read, so the hand-off lands with the last read
      ST_RUN: begin
        if (issued_d == len_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (written_d == len_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (glb_enable && cs_continue) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      prec_q    <= '0;
      issued_q  <= '0;
      written_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      prec_q    <= prec_d;
      issued_q  <= issued_d;
      written_q <= written_d;
      stall_q   <= stall_d;
    end
  end

  assign cs_ready       = accept;
  assign cs_done        = (state_q == ST_DONE);
  assign cs_idle        = (state_q == ST_IDLE);
  assign data_precision = prec_q;
  assign infifo_read    = rd;
  assign outfifo_write  = wr;
  assign enable_mxu     = adv;
  assign stall_cycles   = stall_q;
  assign state_out      = {2'b00, state_q};

  // Outside a batch nothing may remain in flight.
  a_pipe_empty : assert property (@(posedge clk) disable iff (reset)
    (state_q inside {ST_IDLE, ST_DONE}) |-> (occupancy == '0));

endmodule

// File: tb/tb_dtpu_batch_ctrl.sv
// Directed self-checking bench for dtpu_batch_ctrl; per-cycle activity is captured
// as bit masks (bit c = cycle c of a window) and compared with hand-derived values.
module tb_dtpu_batch_ctrl;
  import dtpu_batch_ctrl_pkg::*;

  localparam int CNT_W  = 13;
  localparam int PREC_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              glb_enable;
  logic              cs_start;
  logic              cs_continue;
  logic              cs_ready;
  logic              cs_done;
  logic              cs_idle;
  logic [CNT_W-1:0]  cfg_batch_len;
  logic [PREC_W-1:0] cfg_precision;
  logic [PREC_W-1:0] data_precision;
  logic              infifo_is_empty;
  logic              infifo_read;
  logic              outfifo_is_full;
  logic              outfifo_write;
  logic              enable_mxu;
  logic [CNT_W-1:0]  stall_cycles;
  logic [3:0]        state_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] rd_m, wr_m, adv_m, done_m, rdy_m, idle_m;

  dtpu_batch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .glb_enable     (glb_enable),
    .cs_start       (cs_start),
    .cs_continue    (cs_continue),
    .cs_ready       (cs_ready),
    .cs_done        (cs_done),
    .cs_idle        (cs_idle),
    .cfg_batch_len  (cfg_batch_len),
    .cfg_precision  (cfg_precision),
    .data_precision (data_precision),
    .infifo_is_empty(infifo_is_empty),
    .infifo_read    (infifo_read),
    .outfifo_is_full(outfifo_is_full),
    .outfifo_write  (outfifo_write),
    .enable_mxu     (enable_mxu),
    .stall_cycles   (stall_cycles),
    .state_out      (state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called right after a negedge; drives one cycle per iteration and samples 1ns later.
  // Configuration is scrambled on every cycle that does not carry cs_start.
  task automatic run_window(input int n, input logic [CNT_W-1:0] len, input logic [PREC_W-1:0] prec,
                            input logic [63:0] start_m, input logic [63:0] cont_m,
                            input logic [63:0] full_m, input logic [63:0] empty_m,
                            input logic [63:0] dis_m);
    rd_m = '0; wr_m = '0; adv_m = '0; done_m = '0; rdy_m = '0; idle_m = '0;
    for (int c = 0; c < n; c++) begin
      cs_start        = start_m[c];
      cs_continue     = cont_m[c];
      outfifo_is_full = full_m[c];
      infifo_is_empty = empty_m[c];
      glb_enable      = ~dis_m[c];
      cfg_batch_len   = start_m[c] ? len : 13'd999;
      cfg_precision   = start_m[c] ? prec : ~prec;
      #1;
      rd_m[c]   = infifo_read;
      wr_m[c]   = outfifo_write;
      adv_m[c]  = enable_mxu;
      done_m[c] = cs_done;
      rdy_m[c]  = cs_ready;
      idle_m[c] = cs_idle;
      @(negedge clk);
    end
    cs_start = 1'b0; cs_continue = 1'b0; outfifo_is_full = 1'b0;
    infifo_is_empty = 1'b0; glb_enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (cs_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b exp 1", cs_idle); end
    n_checks++; if (cs_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", cs_done); end
    n_checks++; if (cs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b exp 0", cs_ready); end
    n_checks++; if ({infifo_read, outfifo_write, enable_mxu} !== 3'b000) begin n_fail++;
      $display("FAIL reset_datapath: got %b exp 000", {infifo_read, outfifo_write, enable_mxu}); end
    n_checks++; if (state_out !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state_out); end
    n_checks++; if (stall_cycles !== 13'd0) begin n_fail++; $display("FAIL reset_stall: got %0d exp 0", stall_cycles); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_window(20, 13'd5, PREC_INT2, 64'h1, 64'h8000, 64'h0, 64'h0, 64'h0);
    n_checks++; if (rdy_m !== 64'h1) begin n_fail++; $display("FAIL basic_ready: got %h exp %h", rdy_m, 64'h1); end
    n_checks++; if (rd_m !== 64'h3E) begin n_fail++; $display("FAIL basic_reads: got %h exp %h", rd_m, 64'h3E); end
    n_checks++; if (wr_m !== 64'h1F00) begin n_fail++; $display("FAIL basic_writes: got %h exp %h", wr_m, 64'h1F00); end
    n_checks++; if (adv_m !== 64'h1FFE) begin n_fail++; $display("FAIL basic_adv: got %h exp %h", adv_m, 64'h1FFE); end
    n_checks++; if (done_m !== 64'hE000) begin n_fail++; $display("FAIL basic_done: got %h exp %h", done_m, 64'hE000); end
    n_checks++; if (idle_m !== 64'hF0001) begin n_fail++; $display("FAIL basic_idle: got %h exp %h", idle_m, 64'hF0001); end
    n_checks++; if (stall_cycles !== 13'd0) begin n_fail++; $display("FAIL basic_stall: got %0d exp 0", stall_cycles); end
    n_checks++; if (data_precision !== PREC_INT2) begin n_fail++;
      $display("FAIL basic_precision: got %0d exp %0d", data_precision, PREC_INT2); end
  endtask

  task automatic test_len_zero();
    run_window(6, 13'd0, PREC_INT4, 64'h1, 64'h8, 64'h0, 64'h0, 64'h0);
    n_checks++; if (rdy_m !== 64'h1) begin n_fail++; $display("FAIL len0_ready: got %h exp %h", rdy_m, 64'h1); end
    n_checks++; if ((rd_m | wr_m | adv_m) !== 64'h0) begin n_fail++;
      $display("FAIL len0_activity: got %h exp 0", rd_m | wr_m | adv_m); end
    n_checks++; if (done_m !== 64'hE) begin n_fail++; $display("FAIL len0_done: got %h exp %h", done_m, 64'hE); end
    n_checks++; if (idle_m !== 64'h31) begin n_fail++; $display("FAIL len0_idle: got %h exp %h", idle_m, 64'h31); end
  endtask

  task automatic test_backpressure();
    run_window(18, 13'd4, PREC_INT8, 64'h1, 64'h10000, 64'hE00, 64'h0, 64'h0);
    n_checks++; if (rd_m !== 64'h1E) begin n_fail++; $display("FAIL bp_reads: got %h exp %h", rd_m, 64'h1E); end
    n_checks++; if (wr_m !== 64'h7100) begin n_fail++; $display("FAIL bp_writes: got %h exp %h", wr_m, 64'h7100); end
    n_checks++; if (adv_m !== 64'h71FE) begin n_fail++; $display("FAIL bp_adv: got %h exp %h", adv_m, 64'h71FE); end
    n_checks++; if (done_m !== 64'h18000) begin n_fail++; $display("FAIL bp_done: got %h exp %h", done_m, 64'h18000); end
    n_checks++; if (idle_m !== 64'h20001) begin n_fail++; $display("FAIL bp_idle: got %h exp %h", idle_m, 64'h20001); end
    n_checks++; if (stall_cycles !== 13'd3) begin n_fail++; $display("FAIL bp_stall: got %0d exp 3", stall_cycles); end
  endtask

  task automatic test_bubbles();
    run_window(17, 13'd4, PREC_BIN, 64'h1, 64'h8000, 64'h0, 64'hC, 64'h0);
    n_checks++; if (rd_m !== 64'h72) begin n_fail++; $display("FAIL bub_reads: got %h exp %h", rd_m, 64'h72); end
    n_checks++; if (wr_m !== 64'h3900) begin n_fail++; $display("FAIL bub_writes: got %h exp %h", wr_m, 64'h3900); end
    n_checks++; if (adv_m !== 64'h3FFE) begin n_fail++; $display("FAIL bub_adv: got %h exp %h", adv_m, 64'h3FFE); end
    n_checks++; if (done_m !== 64'hC000) begin n_fail++; $display("FAIL bub_done: got %h exp %h", done_m, 64'hC000); end
    n_checks++; if (idle_m !== 64'h10001) begin n_fail++; $display("FAIL bub_idle: got %h exp %h", idle_m, 64'h10001); end
  endtask

  task automatic test_freeze_reset();
    run_window(12, 13'd5, PREC_BIN, 64'h1, 64'h0, 64'h0, 64'h0, 64'hF8);
    n_checks++; if (rd_m !== 64'h706) begin n_fail++; $display("FAIL frz_reads: got %h exp %h", rd_m, 64'h706); end
    n_checks++; if (adv_m !== 64'hF06) begin n_fail++; $display("FAIL frz_adv: got %h exp %h", adv_m, 64'hF06); end
    n_checks++; if (wr_m !== 64'h0) begin n_fail++; $display("FAIL frz_writes: got %h exp 0", wr_m); end
    n_checks++; if (state_out !== 4'd2) begin n_fail++; $display("FAIL frz_state: got %0d exp 2", state_out); end
    reset = 1'b1;
    #1;
    n_checks++; if ({cs_idle, cs_done, enable_mxu, infifo_read, outfifo_write} !== 5'b10000) begin n_fail++;
      $display("FAIL rst_mid_outputs: got %b exp 10000", {cs_idle, cs_done, enable_mxu, infifo_read, outfifo_write}); end
    n_checks++; if (data_precision !== 2'd0) begin n_fail++; $display("FAIL rst_mid_prec: got %0d exp 0", data_precision); end
    n_checks++; if (state_out !== 4'd0) begin n_fail++; $display("FAIL rst_mid_state: got %0d exp 0", state_out); end
    @(negedge clk);
    reset = 1'b0;
    run_window(12, 13'd0, PREC_INT8, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
    n_checks++; if ((wr_m | adv_m) !== 64'h0) begin n_fail++; $display("FAIL rst_discard: got %h exp 0", wr_m | adv_m); end
    n_checks++; if (idle_m !== 64'hFFF) begin n_fail++; $display("FAIL rst_idle: got %h exp %h", idle_m, 64'hFFF); end
  endtask

  task automatic test_back_to_back();
    run_window(17, 13'd2, PREC_INT4, 64'h1FFFF, 64'h2000, 64'h0, 64'h0, 64'h0);
    n_checks++; if (rdy_m !== 64'h4001) begin n_fail++; $display("FAIL b2b_ready: got %h exp %h", rdy_m, 64'h4001); end
    n_checks++; if (rd_m !== 64'h18006) begin n_fail++; $display("FAIL b2b_reads: got %h exp %h", rd_m, 64'h18006); end
    n_checks++; if (wr_m !== 64'h300) begin n_fail++; $display("FAIL b2b_writes: got %h exp %h", wr_m, 64'h300); end
    n_checks++; if (adv_m !== 64'h183FE) begin n_fail++; $display("FAIL b2b_adv: got %h exp %h", adv_m, 64'h183FE); end
    n_checks++; if (done_m !== 64'h3C00) begin n_fail++; $display("FAIL b2b_done: got %h exp %h", done_m, 64'h3C00); end
    n_checks++; if (idle_m !== 64'h4001) begin n_fail++; $display("FAIL b2b_idle: got %h exp %h", idle_m, 64'h4001); end
    run_window(10, 13'd0, PREC_INT8, 64'h0, 64'h100, 64'h0, 64'h0, 64'h0);
    n_checks++; if (wr_m !== 64'h60) begin n_fail++; $display("FAIL b2b_second_writes: got %h exp %h", wr_m, 64'h60); end
    n_checks++; if (done_m !== 64'h180) begin n_fail++; $display("FAIL b2b_second_done: got %h exp %h", done_m, 64'h180); end
    n_checks++; if (idle_m !== 64'h200) begin n_fail++; $display("FAIL b2b_second_idle: got %h exp %h", idle_m, 64'h200); end
  endtask

  task automatic test_clamp();
    int  wr_cnt = 0;
    int  rd_cnt = 0;
    bit  seen_done = 1'b0;
    cfg_batch_len = 13'h1FFF;
    cfg_precision = PREC_INT8;
    cs_start = 1'b1;
    @(negedge clk);
    cs_start = 1'b0;
    for (int c = 0; c < 5000 && !seen_done; c++) begin
      #1;
      wr_cnt += int'(outfifo_write);
      rd_cnt += int'(infifo_read);
      seen_done = cs_done;
      @(negedge clk);
    end
    n_checks++; if (seen_done !== 1'b1) begin n_fail++; $display("FAIL clamp_done_timeout: got %b exp 1", seen_done); end
    n_checks++; if (rd_cnt != 4096) begin n_fail++; $display("FAIL clamp_reads: got %0d exp 4096", rd_cnt); end
    n_checks++; if (wr_cnt != 4096) begin n_fail++; $display("FAIL clamp_writes: got %0d exp 4096", wr_cnt); end
    cs_continue = 1'b1;
    @(negedge clk);
    cs_continue = 1'b0;
    #1;
    n_checks++; if (cs_idle !== 1'b1) begin n_fail++; $display("FAIL clamp_idle: got %b exp 1", cs_idle); end
    @(negedge clk);
  endtask

  task automatic test_stall_saturation();
    cfg_batch_len = 13'd1;
    outfifo_is_full = 1'b1;
    cs_start = 1'b1;
    @(negedge clk);
    cs_start = 1'b0;
    repeat (8300) @(negedge clk);
    #1;
    n_checks++; if (stall_cycles !== 13'h1FFF) begin n_fail++; $display("FAIL sat_value: got %h exp 1fff", stall_cycles); end
    n_checks++; if ({state_out, enable_mxu, outfifo_write} !== 6'b0010_00) begin n_fail++;
      $display("FAIL sat_frozen: got %b exp 001000", {state_out, enable_mxu, outfifo_write}); end
    @(negedge clk);
    outfifo_is_full = 1'b0;
    #1;
    n_checks++; if (outfifo_write !== 1'b1) begin n_fail++; $display("FAIL sat_release_write: got %b exp 1", outfifo_write); end
    @(negedge clk);
    #1;
    n_checks++; if ({cs_done, stall_cycles} !== {1'b1, 13'h1FFF}) begin n_fail++;
      $display("FAIL sat_done_hold: got %b/%h exp 1/1fff", cs_done, stall_cycles); end
    @(negedge clk);
    cs_continue = 1'b1;
    @(negedge clk);
    cs_continue = 1'b0;
    cfg_batch_len = 13'd0;
    cs_start = 1'b1;
    #1;
    n_checks++; if (cs_ready !== 1'b1) begin n_fail++; $display("FAIL sat_restart_ready: got %b exp 1", cs_ready); end
    @(negedge clk);
    cs_start = 1'b0;
    #1;
    n_checks++; if (stall_cycles !== 13'd0) begin n_fail++; $display("FAIL sat_clear_on_start: got %h exp 0", stall_cycles); end
    @(negedge clk);
    cs_continue = 1'b1;
    @(negedge clk);
    cs_continue = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; glb_enable = 1'b1; cs_start = 1'b0; cs_continue = 1'b0;
    cfg_batch_len = '0; cfg_precision = '0; infifo_is_empty = 1'b0; outfifo_is_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_bubbles();
    test_freeze_reset();
    test_back_to_back();
    test_clamp();
    test_stall_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
